// File: rtl/sad_accum_16.sv
// ============================================================================
// Module      : sad_accum_16
// Description : 16-way parallel sum-of-absolute-differences accumulator over
//               one block of luma samples, with saturating accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_accum_16 #(
    parameter int PIXEL_BIT_DEPTH   = 8,
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int BLOCK_PIXELS      = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           pixel_valid,
    input  logic [PIXEL_BIT_DEPTH-1:0]     cur_pixel,
    input  logic [PIXEL_BIT_DEPTH*16-1:0]  ref_pixels,
    output logic                           pixel_ready,
    output logic [ELEMENT_BIT_DEPTH*16-1:0] sad_array,
    output logic                           sad_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int c_CNT_W = $clog2(BLOCK_PIXELS) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLOCK_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_pixel_ready;
    logic                 r_sad_valid;
    logic                 r_busy;

    logic                 w_clear;
    logic                 w_accept;
    logic [c_CNT_W-1:0]   w_count_next;

    assign w_clear      = (r_state == S_IDLE) && start;
    assign w_accept     = (r_state == S_ACCUM) && pixel_valid;
    assign w_count_next = r_count + c_CNT_W'(1);

    assign pixel_ready  = r_pixel_ready;
    assign sad_valid    = r_sad_valid;
    assign busy         = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_pixel_ready <= 1'b0;
            r_sad_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_ACCUM;
                        r_count       <= '0;
                        r_pixel_ready <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (pixel_valid) begin
                        r_count <= w_count_next;
                        // The sample that completes the block is still summed this edge.
                        if (w_count_next == c_LAST) begin
                            r_state       <= S_DONE;
                            r_pixel_ready <= 1'b0;
                            r_sad_valid   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_sad_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_pixel_ready <= 1'b0;
                    r_sad_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < 16; i++) begin : g_lane
            logic [PIXEL_BIT_DEPTH-1:0]     w_ref;
            logic signed [PIXEL_BIT_DEPTH:0] w_diff;
            logic [PIXEL_BIT_DEPTH-1:0]     w_abs;
            logic [ELEMENT_BIT_DEPTH:0]     w_sum;
            logic [ELEMENT_BIT_DEPTH-1:0]   w_sat;
            logic [ELEMENT_BIT_DEPTH-1:0]   r_acc;

            assign w_ref  = ref_pixels[i*PIXEL_BIT_DEPTH +: PIXEL_BIT_DEPTH];
            assign w_diff = $signed({1'b0, cur_pixel}) - $signed({1'b0, w_ref});
            assign w_abs  = w_diff[PIXEL_BIT_DEPTH] ? PIXEL_BIT_DEPTH'(-w_diff)
                                                    : PIXEL_BIT_DEPTH'(w_diff);
            // One spare bit catches the carry so the sum clamps instead of wrapping.
            assign w_sum  = {1'b0, r_acc} + (ELEMENT_BIT_DEPTH+1)'(w_abs);
            assign w_sat  = w_sum[ELEMENT_BIT_DEPTH] ? {ELEMENT_BIT_DEPTH{1'b1}}
                                                     : w_sum[ELEMENT_BIT_DEPTH-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_clear) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    r_acc <= w_sat;
                end
            end

            assign sad_array[i*ELEMENT_BIT_DEPTH +: ELEMENT_BIT_DEPTH] = r_acc;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sad_accum_16.sv
// ============================================================================
// Module      : tb_sad_accum_16
// Description : Directed self-checking bench for sad_accum_16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_accum_16;

    localparam int c_P = 8;
    localparam int c_E = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start2;
    logic              pixel_valid;
    logic [c_P-1:0]    cur_pixel;
    logic [c_P*16-1:0] ref_pixels;
    logic              out_ready;

    logic              pixel_ready, sad_valid, busy;
    logic [c_E*16-1:0] sad_array;
    logic              pixel_ready2, sad_valid2, busy2;
    logic [c_E*16-1:0] sad_array2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sad_accum_16 #(.PIXEL_BIT_DEPTH(c_P), .ELEMENT_BIT_DEPTH(c_E), .BLOCK_PIXELS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid),
        .cur_pixel(cur_pixel), .ref_pixels(ref_pixels), .pixel_ready(pixel_ready),
        .sad_array(sad_array), .sad_valid(sad_valid), .out_ready(out_ready), .busy(busy)
    );

    sad_accum_16 #(.PIXEL_BIT_DEPTH(c_P), .ELEMENT_BIT_DEPTH(c_E), .BLOCK_PIXELS(128)) dut128 (
        .clk(clk), .rst(rst), .start(start2), .pixel_valid(pixel_valid),
        .cur_pixel(cur_pixel), .ref_pixels(ref_pixels), .pixel_ready(pixel_ready2),
        .sad_array(sad_array2), .sad_valid(sad_valid2), .out_ready(out_ready), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [c_P-1:0] c, input logic [c_P*16-1:0] r);
        pixel_valid = 1'b1;
        cur_pixel   = c;
        ref_pixels  = r;
        step();
        pixel_valid = 1'b0;
    endtask

    function automatic logic [c_P*16-1:0] refs_lin(input int base, input int slope);
        logic [c_P*16-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*c_P +: c_P] = c_P'(base + slope*i);
        return r;
    endfunction

    function automatic logic [c_E*16-1:0] exp_sad(input int c, input int base, input int slope, input int n);
        logic [c_E*16-1:0] e;
        int d, v;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            d = c - (base + slope*i);
            if (d < 0) d = -d;
            v = d * n;
            if (v > 16383) v = 16383;
            e[i*c_E +: c_E] = c_E'(v);
        end
        return e;
    endfunction

    initial begin
        logic [c_E*16-1:0] held;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; pixel_valid = 1'b0;
        cur_pixel = '0; ref_pixels = '0; out_ready = 1'b0;
        #3;
        chk("reset_sad_array", sad_array, '0);
        chk("reset_sad_valid", sad_valid, 1'b0);
        chk("reset_pixel_ready", pixel_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        #9 rst = 1'b0;
        step();

        // Uniform block: element i = 64*i
        start = 1'b1; step(); start = 1'b0;
        chk("uni_pixel_ready", pixel_ready, 1'b1);
        chk("uni_busy", busy, 1'b1);
        for (int k = 0; k < 64; k++) begin
            send(8'd200, refs_lin(200, -1));
            if (k == 62) chk("uni_valid_early", sad_valid, 1'b0);
        end
        chk("uni_sad_valid", sad_valid, 1'b1);
        chk("uni_sad_array", sad_array, exp_sad(200, 200, -1, 64));
        chk("uni_elem15", sad_array[15*c_E +: c_E], 14'd960);
        chk("uni_ready_done", pixel_ready, 1'b0);
        chk("uni_busy_done", busy, 1'b1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("uni_idle_busy", busy, 1'b0);
        chk("uni_idle_valid", sad_valid, 1'b0);

        // Gapped input, then backpressure on the held result
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            chk("gap_ready", pixel_ready, 1'b1);
            send(8'd200, refs_lin(200, -1));
            if (k < 63) begin
                step();
                chk("gap_ready_idle", pixel_ready, 1'b1);
            end
            if (k == 20) repeat (10) step();
        end
        chk("gap_sad_valid", sad_valid, 1'b1);
        chk("gap_sad_array", sad_array, exp_sad(200, 200, -1, 64));
        held = exp_sad(200, 200, -1, 64);
        for (int k = 0; k < 20; k++) begin
            pixel_valid = k[0];
            start       = ~k[0];
            cur_pixel   = 8'd0;
            ref_pixels  = {16{8'hFF}};
            step();
            chk("bp_sad_array", sad_array, held);
            chk("bp_sad_valid", sad_valid, 1'b1);
        end
        pixel_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        chk("bp_release_busy", busy, 1'b0);
        chk("bp_release_ready", pixel_ready, 1'b0);
        chk("bp_release_valid", sad_valid, 1'b0);
        step();
        chk("bp_start_ignored", busy, 1'b0);

        // Max / saturation on both block sizes
        start = 1'b1; start2 = 1'b1; step(); start = 1'b0; start2 = 1'b0;
        for (int k = 0; k < 128; k++) begin
            send(8'd255, '0);
            if (k == 63) begin
                chk("max64_valid", sad_valid, 1'b1);
                chk("max64_sad_array", sad_array, exp_sad(255, 0, 0, 64));
                chk("max128_not_done", sad_valid2, 1'b0);
            end
        end
        chk("max64_held", sad_array, exp_sad(255, 0, 0, 64));
        chk("sat128_valid", sad_valid2, 1'b1);
        chk("sat128_sad_array", sad_array2, {16{14'h3FFF}});
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Reset mid-block
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 30; k++) send(8'd17, refs_lin(3, 9));
        #2 rst = 1'b1;
        #1;
        chk("rst_sad_array", sad_array, '0);
        chk("rst_sad_valid", sad_valid, 1'b0);
        chk("rst_pixel_ready", pixel_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        #3 rst = 1'b0;
        step();
        send(8'd255, '0);
        chk("rst_nostart_ready", pixel_ready, 1'b0);
        chk("rst_nostart_array", sad_array, '0);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 64; k++) send(8'd17, refs_lin(3, 9));
        chk("rst_fresh_valid", sad_valid, 1'b1);
        chk("rst_fresh_array", sad_array, exp_sad(17, 3, 9, 64));

        // Back-to-back blocks
        out_ready = 1'b1; step(); out_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("b2b_cleared", sad_array, '0);
        chk("b2b_ready", pixel_ready, 1'b1);
        for (int k = 0; k < 64; k++) send(8'd0, refs_lin(15, -1));
        chk("b2b_valid", sad_valid, 1'b1);
        chk("b2b_sad_array", sad_array, exp_sad(0, 15, -1, 64));
        out_ready = 1'b1; step(); out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
